// File: rtl/fifo_stream_merger.sv
// rtl/fifo_stream_merger.sv - per-channel packet buffers merged round-robin onto one stream
//
// Purpose:
//    Each input channel owns a DEPTH-entry buffer of {send, data} entries. Once a
//    channel holds at least one complete packet, it is granted round-robin from
//    last_grant+1. The whole packet is then streamed out before any other channel
//    is considered, so packets are never interleaved.
//
// Ports:
//    clk_clk        in   clock, rising edge
//    reset_reset    in   synchronous active-high reset
//    in_fifo_data   in   N_CH beats, channel i at [i*DATA_W +: DATA_W]
//    in_fifo_write  in   per-channel beat valid
//    in_fifo_send   in   per-channel end-of-packet, qualified by in_fifo_write
//    in_fifo_full   out  per-channel buffer holds DEPTH entries
//    out_fifo_data  out  merged beat, registered, holds when idle
//    out_fifo_write out  merged beat valid, one cycle per beat
//    out_fifo_send  out  last beat of packet
//    out_fifo_chan  out  source channel of the current beat
//    out_fifo_full  in   downstream backpressure, stalls popping
//    drop_cnt       out  per-channel 16-bit dropped-beat counters
//
// Macro FIFO_STREAM_MERGER_DROP_CNT_EN enables the saturating drop counters;
// without it drop_cnt is tied to zero.

module fifo_stream_merger #(
   parameter int N_CH   = 5,
   parameter int DATA_W = 256,
   parameter int DEPTH  = 16,
   parameter int CHID_W = 3
) (
   input  logic                     clk_clk,
   input  logic                     reset_reset,
   input  logic [N_CH*DATA_W-1:0]   in_fifo_data,
   input  logic [N_CH-1:0]          in_fifo_write,
   input  logic [N_CH-1:0]          in_fifo_send,
   output logic [N_CH-1:0]          in_fifo_full,
   output logic [DATA_W-1:0]        out_fifo_data,
   output logic                     out_fifo_write,
   output logic                     out_fifo_send,
   output logic [CHID_W-1:0]        out_fifo_chan,
   input  logic                     out_fifo_full,
   output logic [N_CH*16-1:0]       drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, XFER} state_t;

   state_t              state_q;
   logic [CHID_W-1:0]   grant_q;
   logic [CHID_W-1:0]   last_grant_q;

   logic [DATA_W:0]     mem_q    [N_CH][DEPTH];
   logic [AW-1:0]       wr_ptr_q [N_CH];
   logic [AW-1:0]       rd_ptr_q [N_CH];
   logic [CW-1:0]       cnt_q    [N_CH];
   logic [CW-1:0]       pkt_q    [N_CH];

   logic [DATA_W-1:0]   out_data_q;
   logic                out_write_q;
   logic                out_send_q;
   logic [CHID_W-1:0]   out_chan_q;

   logic [N_CH-1:0]     push;
   logic [N_CH-1:0]     pop_ch;
   logic [N_CH-1:0]     has_pkt;
   logic [N_CH-1:0]     pkt_inc;
   logic [N_CH-1:0]     pkt_dec;
   logic                pop;
   logic [DATA_W:0]     head;
   logic                found;
   logic [CHID_W-1:0]   cand;

   // The granted channel always holds its send beat, so a pop never underflows.
   assign pop  = (state_q == XFER) && !out_fifo_full;
   assign head = mem_q[grant_q][rd_ptr_q[grant_q]];

   // Full is taken from the registered count, i.e. before any same-cycle pop.
   always_comb begin
      in_fifo_full = '0;
      push         = '0;
      pop_ch       = '0;
      has_pkt      = '0;
      pkt_inc      = '0;
      pkt_dec      = '0;
      for (int i = 0; i < N_CH; i++) begin
         in_fifo_full[i] = (cnt_q[i] == CW'(DEPTH));
         push[i]         = in_fifo_write[i] && !in_fifo_full[i];
         pop_ch[i]       = pop && (grant_q == CHID_W'(i));
         has_pkt[i]      = (pkt_q[i] != '0);
         pkt_inc[i]      = push[i] && in_fifo_send[i];
         pkt_dec[i]      = pop_ch[i] && head[DATA_W];
      end
   end

   // Round-robin search: the second loop overrides the first, so the lowest
   // channel above last_grant wins, else the lowest channel at or below it.
   always_comb begin
      found = 1'b0;
      cand  = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (has_pkt[i] && (i <= int'(last_grant_q))) begin
            found = 1'b1;
            cand  = CHID_W'(i);
         end
      end
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (has_pkt[i] && (i > int'(last_grant_q))) begin
            found = 1'b1;
            cand  = CHID_W'(i);
         end
      end
   end

   always_ff @(posedge clk_clk) begin
      for (int i = 0; i < N_CH; i++) begin
         if (push[i]) begin
            mem_q[i][wr_ptr_q[i]] <= {in_fifo_send[i], in_fifo_data[i*DATA_W +: DATA_W]};
         end
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= CHID_W'(N_CH - 1);
         out_data_q   <= '0;
         out_write_q  <= 1'b0;
         out_send_q   <= 1'b0;
         out_chan_q   <= '0;
         for (int i = 0; i < N_CH; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
            pkt_q[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (push[i])   wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
            if (pop_ch[i]) rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
            if (push[i] && !pop_ch[i])      cnt_q[i] <= cnt_q[i] + CW'(1);
            else if (pop_ch[i] && !push[i]) cnt_q[i] <= cnt_q[i] - CW'(1);
            if (pkt_inc[i] && !pkt_dec[i])      pkt_q[i] <= pkt_q[i] + CW'(1);
            else if (pkt_dec[i] && !pkt_inc[i]) pkt_q[i] <= pkt_q[i] - CW'(1);
         end

         out_write_q <= pop;
         if (pop) begin
            out_data_q <= head[DATA_W-1:0];
            out_send_q <= head[DATA_W];
            out_chan_q <= grant_q;
         end else begin
            out_send_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (found) begin
                  grant_q <= cand;
                  state_q <= XFER;
               end
            end
            XFER: begin
               if (pop && head[DATA_W]) begin
                  last_grant_q <= grant_q;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_fifo_data  = out_data_q;
   assign out_fifo_write = out_write_q;
   assign out_fifo_send  = out_send_q;
   assign out_fifo_chan  = out_chan_q;

`ifdef FIFO_STREAM_MERGER_DROP_CNT_EN
   logic [15:0] drop_q [N_CH];

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         for (int i = 0; i < N_CH; i++) drop_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (in_fifo_write[i] && in_fifo_full[i] && (drop_q[i] != 16'hFFFF)) begin
               drop_q[i] <= drop_q[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      drop_cnt = '0;
      for (int i = 0; i < N_CH; i++) drop_cnt[i*16 +: 16] = drop_q[i];
   end
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_merger.sv
// tb/tb_fifo_stream_merger.sv - directed self-checking bench for fifo_stream_merger

module tb_fifo_stream_merger;

   localparam int N_CH   = 5;
   localparam int DATA_W = 256;
   localparam int DEPTH  = 16;
   localparam int CHID_W = 3;

   logic                   clk;
   logic                   reset;
   logic [N_CH*DATA_W-1:0] in_fifo_data;
   logic [N_CH-1:0]        in_fifo_write;
   logic [N_CH-1:0]        in_fifo_send;
   logic [N_CH-1:0]        in_fifo_full;
   logic [DATA_W-1:0]      out_fifo_data;
   logic                   out_fifo_write;
   logic                   out_fifo_send;
   logic [CHID_W-1:0]      out_fifo_chan;
   logic                   out_fifo_full;
   logic [N_CH*16-1:0]     drop_cnt;

   int total = 0;
   int bad   = 0;

   fifo_stream_merger #(
      .N_CH   (N_CH),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CHID_W (CHID_W)
   ) dut (
      .clk_clk        (clk),
      .reset_reset    (reset),
      .in_fifo_data   (in_fifo_data),
      .in_fifo_write  (in_fifo_write),
      .in_fifo_send   (in_fifo_send),
      .in_fifo_full   (in_fifo_full),
      .out_fifo_data  (out_fifo_data),
      .out_fifo_write (out_fifo_write),
      .out_fifo_send  (out_fifo_send),
      .out_fifo_chan  (out_fifo_chan),
      .out_fifo_full  (out_fifo_full),
      .drop_cnt       (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input int ch, input logic [255:0] d);
      in_fifo_data[ch*DATA_W +: DATA_W] = d;
   endtask

   task automatic clr_in();
      in_fifo_write = '0;
      in_fifo_send  = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_beat(input string tag, input logic [255:0] d, input logic s, input logic [2:0] c);
      chk({tag, "_write"}, 256'(out_fifo_write), 256'(1'b1));
      chk({tag, "_send"},  256'(out_fifo_send),  256'(s));
      chk({tag, "_chan"},  256'(out_fifo_chan),  256'(c));
      chk({tag, "_data"},  256'(out_fifo_data),  d);
   endtask

   logic       t2_w [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic       t2_s [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [2:0] t2_c [9] = '{3'd1, 3'd1, 3'd0, 3'd2, 3'd2, 3'd0, 3'd4, 3'd4, 3'd0};
   logic [7:0] t2_d [9] = '{8'h11, 8'h12, 8'h00, 8'h21, 8'h22, 8'h00, 8'h41, 8'h42, 8'h00};

   logic [15:0] exp_drop;

   initial begin
      in_fifo_data  = '0;
      clr_in();
      out_fifo_full = 1'b0;
      reset         = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // reset state
      chk("rst_write", 256'(out_fifo_write), 256'(1'b0));
      chk("rst_send",  256'(out_fifo_send),  256'(1'b0));
      chk("rst_chan",  256'(out_fifo_chan),  256'(3'd0));
      chk("rst_data",  256'(out_fifo_data),  256'(0));
      chk("rst_full",  256'(in_fifo_full),   256'(5'b00000));
      chk("rst_drop",  256'(drop_cnt),       256'(0));

      // single 3-beat packet on channel 0
      in_fifo_write = 5'b00001;
      set_data(0, 256'h101); tick();
      set_data(0, 256'h102); tick();
      set_data(0, 256'h103); in_fifo_send = 5'b00001; tick();
      clr_in();
      chk("t1_idle0", 256'(out_fifo_write), 256'(1'b0));
      tick();
      chk("t1_idle1", 256'(out_fifo_write), 256'(1'b0));
      tick(); chk_beat("t1_b1", 256'h101, 1'b0, 3'd0);
      tick(); chk_beat("t1_b2", 256'h102, 1'b0, 3'd0);
      tick(); chk_beat("t1_b3", 256'h103, 1'b1, 3'd0);
      tick();
      chk("t1_end_write", 256'(out_fifo_write), 256'(1'b0));
      chk("t1_end_send",  256'(out_fifo_send),  256'(1'b0));
      chk("t1_hold_data", 256'(out_fifo_data),  256'h103);

      // three channels ready at once: round-robin order 1, 2, 4
      do_reset();
      in_fifo_write = 5'b10110;
      set_data(1, 256'h11); set_data(2, 256'h21); set_data(4, 256'h41); tick();
      set_data(1, 256'h12); set_data(2, 256'h22); set_data(4, 256'h42);
      in_fifo_send = 5'b10110; tick();
      clr_in();
      tick();
      chk("t2_lat", 256'(out_fifo_write), 256'(1'b0));
      for (int k = 0; k < 9; k++) begin
         tick();
         chk($sformatf("t2_write%0d", k), 256'(out_fifo_write), 256'(t2_w[k]));
         chk($sformatf("t2_send%0d", k),  256'(out_fifo_send),  256'(t2_s[k]));
         if (t2_w[k]) begin
            chk($sformatf("t2_chan%0d", k), 256'(out_fifo_chan), 256'(t2_c[k]));
            chk($sformatf("t2_data%0d", k), 256'(out_fifo_data), 256'(t2_d[k]));
         end
      end

      // overflow channel 3 with 20 beats and no send
      do_reset();
      in_fifo_write = 5'b01000;
      for (int b = 1; b <= 20; b++) begin
         set_data(3, 256'(b));
         tick();
         if (b == 15) chk("t3_full15", 256'(in_fifo_full), 256'(5'b00000));
         if (b == 16) chk("t3_full16", 256'(in_fifo_full), 256'(5'b01000));
         chk($sformatf("t3_nowrite%0d", b), 256'(out_fifo_write), 256'(1'b0));
      end
      clr_in();
      tick();
`ifdef FIFO_STREAM_MERGER_DROP_CNT_EN
      exp_drop = 16'd4;
`else
      exp_drop = 16'd0;
`endif
      chk("t3_drop3",    256'(drop_cnt[3*16 +: 16]), 256'(exp_drop));
      chk("t3_drop_oth", 256'(drop_cnt & ~(80'hFFFF << 48)), 256'(0));
      chk("t3_full_end", 256'(in_fifo_full), 256'(5'b01000));
      chk("t3_nowrite",  256'(out_fifo_write), 256'(1'b0));

      // backpressure stall of 5 cycles mid-packet on channel 2
      do_reset();
      in_fifo_write = 5'b00100;
      for (int b = 1; b <= 6; b++) begin
         set_data(2, 256'h200 + 256'(b));
         if (b == 6) in_fifo_send = 5'b00100;
         tick();
      end
      clr_in();
      tick();
      chk("t4_lat", 256'(out_fifo_write), 256'(1'b0));
      tick(); chk_beat("t4_b1", 256'h201, 1'b0, 3'd2);
      tick(); chk_beat("t4_b2", 256'h202, 1'b0, 3'd2);
      out_fifo_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("t4_stall_w%0d", k), 256'(out_fifo_write), 256'(1'b0));
         chk($sformatf("t4_stall_d%0d", k), 256'(out_fifo_data),  256'h202);
      end
      out_fifo_full = 1'b0;
      for (int b = 3; b <= 6; b++) begin
         tick();
         chk_beat($sformatf("t4_b%0d", b), 256'h200 + 256'(b), (b == 6), 3'd2);
      end
      tick();
      chk("t4_end", 256'(out_fifo_write), 256'(1'b0));

      // reset pulse during beat 2 of a 4-beat packet on channel 1
      do_reset();
      in_fifo_write = 5'b00010;
      for (int b = 1; b <= 4; b++) begin
         set_data(1, 256'h300 + 256'(b));
         if (b == 4) in_fifo_send = 5'b00010;
         tick();
      end
      clr_in();
      tick();
      tick(); chk_beat("t5_b1", 256'h301, 1'b0, 3'd1);
      tick(); chk_beat("t5_b2", 256'h302, 1'b0, 3'd1);
      reset         = 1'b1;
      in_fifo_write = 5'b00001;
      in_fifo_send  = 5'b00001;
      set_data(0, 256'hDEAD);
      tick();
      reset = 1'b0;
      clr_in();
      chk("t5_rst_write", 256'(out_fifo_write), 256'(1'b0));
      chk("t5_rst_send",  256'(out_fifo_send),  256'(1'b0));
      chk("t5_rst_chan",  256'(out_fifo_chan),  256'(3'd0));
      chk("t5_rst_data",  256'(out_fifo_data),  256'(0));
      chk("t5_rst_full",  256'(in_fifo_full),   256'(5'b00000));
      // send without write must be ignored
      in_fifo_send = 5'b00001;
      tick();
      in_fifo_send = '0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("t5_quiet%0d", k), 256'(out_fifo_write), 256'(1'b0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
